// File: rtl/pipelined_adder_if.sv
// Handshake and data bundle for pipelined_adder.
// The master drives the operands and the output ready. The slave is the adder.
// The nzp_* flags exist only when PIPELINED_ADDER_NZP_EN is defined.
interface pipelined_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
`ifdef PIPELINED_ADDER_NZP_EN
   logic             nzp_n;
   logic             nzp_z;
   logic             nzp_p;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, nzp_n, nzp_z, nzp_p
   );
   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf, nzp_n, nzp_z, nzp_p
   );
`else
   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );
   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
`endif
endinterface

// File: rtl/pipelined_adder.sv
// Segmented, pipelined add/subtract unit.
// A WIDTH-bit operation is resolved SEG_WIDTH bits per stage, and the carry is
// registered between stages. Each stage holds one beat under a valid/ready
// handshake. Empty stages always accept data, so bubbles collapse.
// Optional macro PIPELINED_ADDER_NZP_EN adds registered N/Z/P flags of the result.
// WIDTH must be a multiple of SEG_WIDTH.
module pipelined_adder #(
   parameter int WIDTH     = 16,
   parameter int SEG_WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   pipelined_adder_if.slave bus
);
   localparam int NUM_SEG = WIDTH / SEG_WIDTH;
   localparam int LAST    = NUM_SEG - 1;

   // Per-stage state. Index k is the register set at the output of stage k.
   logic [NUM_SEG-1:0] w_adv;
   logic [NUM_SEG-1:0] r_valid;
   logic [NUM_SEG-1:0] r_carry;
   logic [WIDTH-1:0]   r_a   [NUM_SEG];
   logic [WIDTH-1:0]   r_b   [NUM_SEG];   // B is already conditionally inverted
   logic [WIDTH-1:0]   r_sum [NUM_SEG];   // low segments resolved so far
   logic               r_ovf;
`ifdef PIPELINED_ADDER_NZP_EN
   logic               r_nzp_n;
   logic               r_nzp_z;
   logic               r_nzp_p;
`endif

   // Ready chain from the output back to the input: a stage moves if it is empty
   // or if the stage after it moves.
   always_comb begin
      w_adv       = '0;
      w_adv[LAST] = !r_valid[LAST] || bus.out_ready;
      for (int k = LAST - 1; k >= 0; k--) begin
         w_adv[k] = !r_valid[k] || w_adv[k+1];
      end
   end

   for (genvar gi = 0; gi < NUM_SEG; gi++) begin : g_stage
      logic               w_v_in;
      logic               w_c_in;
      logic [WIDTH-1:0]   w_a_in;
      logic [WIDTH-1:0]   w_b_in;
      logic [WIDTH-1:0]   w_s_in;
      logic [WIDTH-1:0]   w_s_out;
      logic [SEG_WIDTH:0] w_seg;

      if (gi == 0) begin : g_first
         // Stage 0 folds the subtract into an inverted B and an inverted carry-in.
         assign w_v_in = bus.in_valid;
         assign w_a_in = bus.a;
         assign w_b_in = bus.sub ? ~bus.b : bus.b;
         assign w_c_in = bus.cin ^ bus.sub;
         assign w_s_in = '0;
      end else begin : g_next
         assign w_v_in = r_valid[gi-1];
         assign w_a_in = r_a[gi-1];
         assign w_b_in = r_b[gi-1];
         assign w_c_in = r_carry[gi-1];
         assign w_s_in = r_sum[gi-1];
      end

      // The segment add is one bit wider than the segment. Its MSB is the carry out.
      assign w_seg = {1'b0, w_a_in[gi*SEG_WIDTH +: SEG_WIDTH]}
                   + {1'b0, w_b_in[gi*SEG_WIDTH +: SEG_WIDTH]}
                   + {{SEG_WIDTH{1'b0}}, w_c_in};

      // Merge this segment's result into the partial sum.
      always_comb begin
         w_s_out = w_s_in;
         w_s_out[gi*SEG_WIDTH +: SEG_WIDTH] = w_seg[SEG_WIDTH-1:0];
      end

      // Stage register. It loads only when advancing and holds when stalled.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_valid[gi] <= 1'b0;
            r_carry[gi] <= 1'b0;
            r_a[gi]     <= '0;
            r_b[gi]     <= '0;
            r_sum[gi]   <= '0;
         end else if (w_adv[gi]) begin
            r_valid[gi] <= w_v_in;
            if (w_v_in) begin
               r_carry[gi] <= w_seg[SEG_WIDTH];
               r_a[gi]     <= w_a_in;
               r_b[gi]     <= w_b_in;
               r_sum[gi]   <= w_s_out;
            end
         end
      end

      if (gi == LAST) begin : g_last
         logic w_msb_cin;
         logic w_ovf;
         // Recover the carry into the MSB from the MSB sum bit. This also works when SEG_WIDTH=1.
         assign w_msb_cin = w_a_in[WIDTH-1] ^ w_b_in[WIDTH-1] ^ w_s_out[WIDTH-1];
         assign w_ovf     = w_msb_cin ^ w_seg[SEG_WIDTH];

         // Status flags are registered alongside the final sum.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               r_ovf   <= 1'b0;
`ifdef PIPELINED_ADDER_NZP_EN
               r_nzp_n <= 1'b0;
               r_nzp_z <= 1'b0;
               r_nzp_p <= 1'b0;
`endif
            end else if (w_adv[gi] && w_v_in) begin
               r_ovf   <= w_ovf;
`ifdef PIPELINED_ADDER_NZP_EN
               r_nzp_n <= w_s_out[WIDTH-1];
               r_nzp_z <= (w_s_out == '0);
               r_nzp_p <= !w_s_out[WIDTH-1] && (w_s_out != '0);
`endif
            end
         end
      end
   end

   assign bus.in_ready  = w_adv[0];
   assign bus.out_valid = r_valid[LAST];
   assign bus.sum       = r_sum[LAST];
   assign bus.cout      = r_carry[LAST];
   assign bus.ovf       = r_ovf;
`ifdef PIPELINED_ADDER_NZP_EN
   assign bus.nzp_n     = r_nzp_n;
   assign bus.nzp_z     = r_nzp_z;
   assign bus.nzp_p     = r_nzp_p;
`endif
endmodule
